// File: rtl/kv_frame_parser_pkg.sv
// Shared definitions for the key/value frame parser and the downstream key-value store.
// Holds the start-of-frame marker and the parser state encoding.
package kv_frame_parser_pkg;

    localparam logic [7:0] KV_SOF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_LEN,
        ST_VAL,
        ST_CHK,
        ST_OUT
    } kv_state_e;

endpackage

// File: rtl/kv_frame_parser_sync.sv
// Brings the receiver's newbyt toggle into the clk domain and emits a 1-cycle strobe per toggle.
// Two synchronizer flops followed by a registered edge compare: strobe is 3 clk cycles after the toggle.
module toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_i,
    output logic stb_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic stb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            sync1_q <= tog_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stb_q   <= sync2_q ^ prev_q;
        end
    end

    assign stb_o = stb_q;

endmodule

// File: rtl/kv_frame_parser.sv
// Assembles [SOF][KEY][LEN][VAL..][CHK] frames from received bytes and presents one validated
// key/value record per frame on a valid/ready interface, with single-cycle error pulses.
module kv_frame_parser
    import kv_frame_parser_pkg::*;
#(
    parameter int unsigned MAX_VAL_BYTES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       bus,
    input  logic                             newbyt,
    output logic                             kv_valid,
    input  logic                             kv_ready,
    output logic [7:0]                       kv_key,
    output logic [$clog2(MAX_VAL_BYTES+1)-1:0] kv_len,
    output logic [8*MAX_VAL_BYTES-1:0]       kv_value,
    output logic                             err_chk,
    output logic                             err_len,
    output logic                             err_tmo,
    output logic                             err_ovr
);

    localparam int unsigned LW = $clog2(MAX_VAL_BYTES + 1);
    localparam int unsigned VW = 8 * MAX_VAL_BYTES;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic byte_stb;

    kv_state_e state_q, state_d;
    logic [7:0]    key_q, key_d;
    logic [7:0]    chk_q, chk_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [VW-1:0] val_q, val_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]    kv_key_q, kv_key_d;
    logic [LW-1:0] kv_len_q, kv_len_d;
    logic [VW-1:0] kv_value_q, kv_value_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_tmo_q, err_tmo_d;
    logic          err_ovr_q, err_ovr_d;

    toggle_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .tog_i (newbyt),
        .stb_o (byte_stb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            chk_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            val_q      <= '0;
            tmo_q      <= '0;
            kv_key_q   <= '0;
            kv_len_q   <= '0;
            kv_value_q <= '0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            chk_q      <= chk_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            tmo_q      <= tmo_d;
            kv_key_q   <= kv_key_d;
            kv_len_q   <= kv_len_d;
            kv_value_q <= kv_value_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
            err_ovr_q  <= err_ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        chk_d      = chk_q;
        len_d      = len_q;
        idx_d      = idx_q;
        val_d      = val_q;
        tmo_d      = '0;
        kv_key_d   = kv_key_q;
        kv_len_d   = kv_len_q;
        kv_value_d = kv_value_q;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        err_ovr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (byte_stb && bus == KV_SOF) state_d = ST_KEY;
            end
            ST_KEY: begin
                if (byte_stb) begin
                    key_d   = bus;
                    chk_d   = bus;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_stb) begin
                    if (bus != 8'd0 && 32'(bus) <= MAX_VAL_BYTES) begin
                        len_d   = LW'(bus);
                        chk_d   = chk_q ^ bus;
                        val_d   = '0;
                        idx_d   = '0;
                        state_d = ST_VAL;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_VAL: begin
                if (byte_stb) begin
                    for (int unsigned i = 0; i < MAX_VAL_BYTES; i++) begin
                        if (LW'(i) == idx_q) val_d[8*i +: 8] = bus;
                    end
                    chk_d = chk_q ^ bus;
                    idx_d = idx_q + LW'(1);
                    if (idx_d == len_q) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (byte_stb) begin
                    if (bus == chk_q) begin
                        kv_key_d   = key_q;
                        kv_len_d   = len_q;
                        kv_value_d = val_q;
                        state_d    = ST_OUT;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_OUT: begin
                // A byte arriving with the handshake is parsed as if already back in IDLE.
                if (kv_ready) begin
                    state_d = (byte_stb && bus == KV_SOF) ? ST_KEY : ST_IDLE;
                end else if (byte_stb) begin
                    err_ovr_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // In-frame inter-byte timeout; an arriving byte always beats the expiry.
        if (state_q inside {ST_KEY, ST_LEN, ST_VAL, ST_CHK} && !byte_stb) begin
            if (TIMEOUT_CYCLES != 0 && 32'(tmo_q) + 32'd1 == TIMEOUT_CYCLES) begin
                err_tmo_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                tmo_d = tmo_q + CW'(1);
            end
        end
    end

    assign kv_valid = (state_q == ST_OUT);
    assign kv_key   = kv_key_q;
    assign kv_len   = kv_len_q;
    assign kv_value = kv_value_q;
    assign err_chk  = err_chk_q;
    assign err_len  = err_len_q;
    assign err_tmo  = err_tmo_q;
    assign err_ovr  = err_ovr_q;

endmodule
